// File: rtl/invader_formation_ctrl.sv
// invader_formation_ctrl: march/descent/fire sequencer for the ROWS x COLS enemy grid.
// Owns the formation base position, the alive mask and the march direction, and
// picks the next enemy shooter from an external random column seed.
// Optional macro SPEEDUP_EN: shorten the march period as the alive count drops.
module invader_formation_ctrl #(
  parameter int COLS      = 8,
  parameter int ROWS      = 3,
  parameter int X0        = 40,
  parameter int Y0        = 40,
  parameter int COL_PITCH = 64,
  parameter int ROW_PITCH = 40,
  parameter int ENEMY_W   = 32,
  parameter int ENEMY_H   = 24,
  parameter int STEP_X    = 8,
  parameter int STEP_Y    = 16,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 640,
  parameter int Y_LIMIT   = 400,
  parameter int TICK_DIV  = 2500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 restart,
  input  logic                 hit_valid,
  input  logic [4:0]           hit_index,
  input  logic [7:0]           rnd,
  input  logic                 shot_busy,
  input  logic                 shot_ack,
  output logic [9:0]           base_x,
  output logic [9:0]           base_y,
  output logic [ROWS*COLS-1:0] alive_mask,
  output logic                 shot_req,
  output logic [9:0]           shot_x,
  output logic [9:0]           shot_y,
  output logic                 all_clear,
  output logic                 invaded,
  output logic                 dir_left
);

  localparam int N  = ROWS * COLS;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_STEP, S_FIRE_SCAN, S_FIRE_REQ, S_CLEARED, S_INVADED
  } state_t;

  state_t          state;
  logic [31:0]     tick_cnt;
  logic [31:0]     period_m1;
  logic            count_en;
  logic            tick;
  logic            tick_pend;
  logic [CW-1:0]   scan_col;
  logic [CW-1:0]   scan_cnt;
  logic [COLS-1:0] col_alive;
  logic [ROWS-1:0] row_alive;
  logic [CW-1:0]   l_col;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   b_row;
  logic [RW-1:0]   sel_row;
  logic [N-1:0]    hit_clr;
  logic [10:0]     right_edge, left_edge, desc_y, bottom_y;
  logic [10:0]     step_x_r, step_x_l, muzzle_x, muzzle_y;
  logic            right_hit, left_hit, move_desc, invade_hit;

  // Clamp an 11-bit position into the 10-bit screen coordinate range.
  function automatic logic [9:0] sat10(input logic [10:0] v);
    sat10 = v[10] ? 10'h3FF : v[9:0];
  endfunction

  assign count_en = enable && (state != S_CLEARED) && (state != S_INVADED);
  assign tick     = count_en && (tick_cnt >= period_m1);

`ifdef SPEEDUP_EN
  int alive_cnt;
  // Effective march period shrinks as the formation thins out.
  always_comb begin
    alive_cnt = $countones(alive_mask);
    if (alive_cnt <= 2)          period_m1 = 32'(TICK_DIV / 4 - 1);
    else if (alive_cnt <= N / 3) period_m1 = 32'(TICK_DIV / 2 - 1);
    else                         period_m1 = 32'(TICK_DIV - 1);
  end
`else
  assign period_m1 = 32'(TICK_DIV - 1);
`endif

  // Per-column and per-row occupancy of the current (pre-hit) mask.
  always_comb begin
    col_alive = '0;
    row_alive = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        col_alive[c] = col_alive[c] | alive_mask[r*COLS+c];
        row_alive[r] = row_alive[r] | alive_mask[r*COLS+c];
      end
    end
  end

  // Leftmost / rightmost live column and lowest live row set the formation extent.
  always_comb begin
    l_col = '0;
    r_col = '0;
    b_row = '0;
    for (int c = COLS - 1; c >= 0; c--) if (col_alive[c]) l_col = CW'(c);
    for (int c = 0; c < COLS; c++)      if (col_alive[c]) r_col = CW'(c);
    for (int r = 0; r < ROWS; r++)      if (row_alive[r]) b_row = RW'(r);
  end

  // Lowest live enemy in the column under scan is the shooter.
  always_comb begin
    sel_row = '0;
    for (int r = 0; r < ROWS; r++) if (alive_mask[r*COLS+int'(scan_col)]) sel_row = RW'(r);
  end

  // Decode a valid in-range hit into a one-hot clear mask.
  always_comb begin
    hit_clr = '0;
    for (int k = 0; k < N; k++) if (hit_valid && (hit_index == 5'(k))) hit_clr[k] = 1'b1;
  end

  assign right_edge = {1'b0, base_x} + 11'(r_col) * 11'(COL_PITCH) + 11'(ENEMY_W + STEP_X);
  assign left_edge  = {1'b0, base_x} + 11'(l_col) * 11'(COL_PITCH);
  assign right_hit  = right_edge > 11'(X_MAX);
  assign left_hit   = left_edge < 11'(X_MIN + STEP_X);
  assign move_desc  = dir_left ? left_hit : right_hit;
  assign desc_y     = {1'b0, base_y} + 11'(STEP_Y);
  assign bottom_y   = desc_y + 11'(b_row) * 11'(ROW_PITCH) + 11'(ENEMY_H);
  assign invade_hit = bottom_y >= 11'(Y_LIMIT);
  assign step_x_r   = {1'b0, base_x} + 11'(STEP_X);
  assign step_x_l   = {1'b0, base_x} - 11'(STEP_X);
  assign muzzle_x   = {1'b0, base_x} + 11'(scan_col) * 11'(COL_PITCH) + 11'(ENEMY_W / 2);
  assign muzzle_y   = {1'b0, base_y} + 11'(sel_row) * 11'(ROW_PITCH) + 11'(ENEMY_H);

  // March tick divider; holds while disabled, stops in the terminal states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         tick_cnt <= '0;
    else if (restart)  tick_cnt <= '0;
    else if (count_en) tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
  end

  // Formation sequencer: march, descend, scan for a shooter, hand off the shot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || restart) begin
      state      <= S_IDLE;
      base_x     <= 10'(X0);
      base_y     <= 10'(Y0);
      alive_mask <= '1;
      dir_left   <= 1'b0;
      shot_req   <= 1'b0;
      shot_x     <= '0;
      shot_y     <= '0;
      all_clear  <= 1'b0;
      invaded    <= 1'b0;
      scan_col   <= '0;
      scan_cnt   <= '0;
      tick_pend  <= 1'b0;
    end else begin
      alive_mask <= alive_mask & ~hit_clr;
      if (tick && (state != S_WAIT)) tick_pend <= 1'b1;
      if ((alive_mask == '0) && (state != S_CLEARED) && (state != S_INVADED)) begin
        state     <= S_CLEARED;
        all_clear <= 1'b1;
        shot_req  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (enable) state <= S_WAIT;
          S_WAIT: begin
            if (tick || tick_pend) begin
              state     <= S_STEP;
              tick_pend <= 1'b0;
            end
          end
          S_STEP: begin
            if (move_desc) begin
              base_y   <= sat10(desc_y);
              dir_left <= ~dir_left;
            end else if (dir_left) begin
              base_x <= sat10(step_x_l);
            end else begin
              base_x <= sat10(step_x_r);
            end
            if (move_desc && invade_hit) begin
              state   <= S_INVADED;
              invaded <= 1'b1;
            end else if (!shot_busy && !shot_req) begin
              state    <= S_FIRE_SCAN;
              scan_col <= CW'(rnd % 8'(COLS));
              scan_cnt <= '0;
            end else begin
              state <= S_WAIT;
            end
          end
          S_FIRE_SCAN: begin
            if (col_alive[scan_col]) begin
              shot_x   <= sat10(muzzle_x);
              shot_y   <= sat10(muzzle_y);
              shot_req <= 1'b1;
              state    <= S_FIRE_REQ;
            end else if (scan_cnt == CW'(COLS - 1)) begin
              state <= S_WAIT;
            end else begin
              scan_col <= (scan_col == CW'(COLS - 1)) ? '0 : scan_col + 1'b1;
              scan_cnt <= scan_cnt + 1'b1;
            end
          end
          S_FIRE_REQ: begin
            if (shot_ack) begin
              shot_req <= 1'b0;
              state    <= S_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_invader_formation_ctrl.sv
// Scoreboard bench for invader_formation_ctrl: every expected change of the
// visible outputs is queued before the stimulus that causes it; a negedge
// monitor pops one entry per observed change and compares the full snapshot.
module tb_invader_formation_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic        hit_valid = 1'b0;
  logic [4:0]  hit_index = '0;
  logic [7:0]  rnd = '0;
  logic        shot_busy = 1'b1;
  logic        shot_ack = 1'b0;
  logic [9:0]  base_x, base_y, shot_x, shot_y;
  logic [23:0] alive_mask;
  logic        shot_req, all_clear, invaded, dir_left;

  invader_formation_ctrl #(.TICK_DIV(8), .Y_LIMIT(160)) dut (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .hit_valid(hit_valid), .hit_index(hit_index), .rnd(rnd),
    .shot_busy(shot_busy), .shot_ack(shot_ack),
    .base_x(base_x), .base_y(base_y), .alive_mask(alive_mask),
    .shot_req(shot_req), .shot_x(shot_x), .shot_y(shot_y),
    .all_clear(all_clear), .invaded(invaded), .dir_left(dir_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  bx;
    logic [9:0]  by;
    logic [23:0] mask;
    logic        dir;
    logic        req;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        clr;
    logic        inv;
  } snap_t;

  snap_t q[$];
  snap_t exp_s;
  snap_t prev = '0;
  int    n_checks = 0;
  int    n_pass = 0;

  function automatic snap_t reset_snap();
    snap_t s;
    s.bx = 10'd40; s.by = 10'd40; s.mask = 24'hFFFFFF; s.dir = 1'b0; s.req = 1'b0;
    s.sx = 10'd0;  s.sy = 10'd0;  s.clr = 1'b0; s.inv = 1'b0;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("bx=%0d by=%0d mask=%h dir=%0d req=%0d sx=%0d sy=%0d clr=%0d inv=%0d",
                     s.bx, s.by, s.mask, s.dir, s.req, s.sx, s.sy, s.clr, s.inv);
  endfunction

  task automatic expect_now();
    q.push_back(exp_s);
  endtask

  task automatic pulse_hit(input int idx);
    @(posedge clk); #1;
    hit_valid = 1'b1;
    hit_index = 5'(idx);
    @(posedge clk); #1;
    hit_valid = 1'b0;
  endtask

  // Queue the mask change (if the hit is meaningful) and then apply the hit.
  task automatic kill(input int idx);
    if (idx < 24 && exp_s.mask[idx]) begin
      exp_s.mask[idx] = 1'b0;
      expect_now();
    end
    pulse_hit(idx);
  endtask

  task automatic pulse_restart();
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    int k;
    k = 0;
    while (q.size() != 0 && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL %s timeout: %0d expected events still pending, required 0", tag, q.size());
      q.delete();
    end
  endtask

  // Monitor: any change of the visible outputs must match the next queued snapshot.
  always @(negedge clk) begin
    snap_t cur;
    snap_t e;
    cur = {base_x, base_y, alive_mask, dir_left, shot_req, shot_x, shot_y, all_clear, invaded};
    if (cur !== prev) begin
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_change got %s required %s", fmt(cur), fmt(prev));
      end else begin
        e = q.pop_front();
        if (cur === e) n_pass++;
        else $display("FAIL event got %s required %s", fmt(cur), fmt(e));
      end
      prev = cur;
    end
  end

  initial begin
    // Reset state
    exp_s = reset_snap();
    expect_now();
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_drain(5, "reset_state");

    // March right with the full grid; first descent crosses the invasion line
    shot_busy = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      exp_s.bx = 10'(40 + 8 * k);
      expect_now();
    end
    exp_s.by = 10'd56; exp_s.dir = 1'b1; exp_s.inv = 1'b1;
    expect_now();
    enable = 1'b1;
    wait_drain(400, "march_right");
    repeat (60) @(posedge clk);
    #1 enable = 1'b0;
    exp_s = reset_snap();
    expect_now();
    pulse_restart();
    wait_drain(5, "restart_after_invade");

    // Column 7 and row 2 dead: right edge at 224, then full left march and descent
    kill(7); kill(15);
    for (int i = 16; i < 24; i++) kill(i);
    wait_drain(10, "precut_hits");
    for (int k = 1; k <= 23; k++) begin
      exp_s.bx = 10'(40 + 8 * k);
      expect_now();
    end
    exp_s.by = 10'd56; exp_s.dir = 1'b1;
    expect_now();
    for (int k = 1; k <= 28; k++) begin
      exp_s.bx = 10'(224 - 8 * k);
      expect_now();
    end
    exp_s.by = 10'd72; exp_s.dir = 1'b0;
    expect_now();
    enable = 1'b1;
    wait_drain(1000, "march_edges");
    enable = 1'b0;
    exp_s = reset_snap();
    expect_now();
    pulse_restart();
    wait_drain(5, "restart_after_march");

    // Shooter selection: column 3 dead, column 4 rows 0-1 alive, seed column 3
    kill(3); kill(11); kill(19); kill(20);
    wait_drain(10, "shot_setup_hits");
    rnd = 8'd3;
    shot_busy = 1'b0;
    exp_s.bx = 10'd48;
    expect_now();
    exp_s.req = 1'b1; exp_s.sx = 10'd320; exp_s.sy = 10'd104;
    expect_now();
    enable = 1'b1;
    wait_drain(100, "shot_request");
    kill(12);
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    shot_busy = 1'b1;
    exp_s.req = 1'b0;
    expect_now();
    exp_s.bx = 10'd56;
    expect_now();
    @(posedge clk); #1 shot_ack = 1'b1;
    @(posedge clk); #1 shot_ack = 1'b0;
    wait_drain(50, "shot_ack_pending_step");
    exp_s = reset_snap();
    expect_now();
    pulse_restart();
    wait_drain(5, "restart_after_shot");

    // Clear the whole grid, with a duplicate hit and an out-of-range index
    for (int i = 0; i < 23; i++) begin
      kill(i);
      if (i == 5) begin
        kill(5);
        kill(30);
      end
    end
    exp_s.mask[23] = 1'b0;
    expect_now();
    exp_s.clr = 1'b1;
    expect_now();
    pulse_hit(23);
    wait_drain(10, "all_clear");
    exp_s = reset_snap();
    expect_now();
    pulse_restart();
    wait_drain(5, "restart_after_clear");

    // Asynchronous reset while a shot request is outstanding
    rnd = 8'd5;
    shot_busy = 1'b0;
    exp_s.bx = 10'd48;
    expect_now();
    exp_s.req = 1'b1; exp_s.sx = 10'd384; exp_s.sy = 10'd144;
    expect_now();
    enable = 1'b1;
    wait_drain(100, "second_shot");
    repeat (3) @(posedge clk);
    #1;
    exp_s = reset_snap();
    expect_now();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 enable = 1'b0;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    wait_drain(5, "async_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
